// File: rtl/encode_pkg.sv
// Shared constants for the encode job scheduler: FSM state encodings and default widths.
package encode_pkg;

    localparam int unsigned NCH_DEF        = 4;
    localparam int unsigned CLR_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/encode_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from the channel after the last winner.
module encode_rr_arb
    import encode_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] i_req,
    input  logic           i_upd,
    output logic [NCH-1:0] o_grant
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic [IW:0]   w_pos;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_idx   = r_ptr;
        w_found = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            w_pos = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(NCH))
                w_pos = w_pos - (IW+1)'(NCH);
            if (!w_found && i_req[w_pos[IW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_pos[IW-1:0];
            end
        end
        if (w_found)
            o_grant[w_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_ptr <= '0;
        else if (i_upd && w_found)
            r_ptr <= (w_idx == IW'(NCH-1)) ? '0 : w_idx + IW'(1);
    end

endmodule

// File: rtl/encode_sched.sv
// Shares one encode core between NCH channels: round-robin grant, core history clear,
// handshake steering, per-job output word count and completion pulse.
module encode_sched
    import encode_pkg::*;
#(
    parameter int unsigned NCH        = NCH_DEF,
    parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NCH-1:0]    ch_req,
    input  logic [64*NCH-1:0] ch_fi,
    input  logic [NCH-1:0]    ch_src_empty,
    input  logic [NCH-1:0]    ch_last,
    input  logic [NCH-1:0]    ch_fo_full,
    output logic [NCH-1:0]    ch_grant,
    output logic [NCH-1:0]    ch_src_getn,
    output logic [NCH-1:0]    ch_dst_putn,
    output logic [63:0]       ch_dst,
    output logic              ch_dst_last,
    output logic [NCH-1:0]    ch_done,
    output logic [CNT_W-1:0]  done_words,
    output logic              busy,
    output logic              core_rst,
    output logic              core_ce,
    output logic [63:0]       core_fi,
    output logic              core_src_empty,
    output logic              core_m_last,
    output logic              core_fo_full,
    input  logic              core_src_getn,
    input  logic              core_dst_putn,
    input  logic [63:0]       core_dst,
    input  logic              core_dst_last,
    input  logic              core_endn
);

    localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [NCH-1:0]   r_grant;
    logic [CW-1:0]    r_clr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_done_words;
    logic             r_core_rst;
    logic [NCH-1:0]   w_arb_grant;
    logic             w_arb_upd;
    logic             w_run;
    logic [63:0]      w_fi;
    logic             w_empty;
    logic             w_last;
    logic             w_full;

    assign w_run     = (r_state == ST_RUN);
    assign w_arb_upd = (r_state == ST_IDLE) && (|ch_req);

    encode_rr_arb #(.NCH(NCH)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .i_req   (ch_req),
        .i_upd   (w_arb_upd),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|ch_req) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr == CW'(CLR_CYCLES-1)) w_state_nxt = ST_RUN;
            ST_RUN:   if (!core_endn) w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The finishing push may coincide with core_endn, so done_words takes the incremented value.
    assign w_cnt_inc = (!core_dst_putn && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_clr        <= '0;
            r_cnt        <= '0;
            r_done_words <= '0;
            r_core_rst   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_core_rst <= (w_state_nxt == ST_CLEAR);
            if (w_arb_upd)
                r_grant <= w_arb_grant;
            else if (r_state == ST_DONE)
                r_grant <= '0;
            r_clr <= (r_state == ST_CLEAR) ? r_clr + CW'(1) : '0;
            if (r_state == ST_CLEAR)
                r_cnt <= '0;
            else if (w_run)
                r_cnt <= w_cnt_inc;
            if (w_run && !core_endn)
                r_done_words <= w_cnt_inc;
        end
    end

    always_comb begin
        w_fi    = '0;
        w_empty = 1'b0;
        w_last  = 1'b0;
        w_full  = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (r_grant[i]) begin
                w_fi    = w_fi | ch_fi[64*i +: 64];
                w_empty = w_empty | ch_src_empty[i];
                w_last  = w_last | ch_last[i];
                w_full  = w_full | ch_fo_full[i];
            end
        end
    end

    assign core_fi        = w_run ? w_fi : '0;
    assign core_src_empty = w_run ? w_empty : 1'b1;
    assign core_m_last    = w_run ? w_last : 1'b0;
    assign core_fo_full   = w_run ? w_full : 1'b1;
    assign ch_src_getn    = w_run ? ~(r_grant & {NCH{~core_src_getn}}) : '1;
    assign ch_dst_putn    = w_run ? ~(r_grant & {NCH{~core_dst_putn}}) : '1;

    assign ch_dst      = core_dst;
    assign ch_dst_last = core_dst_last;
    assign ch_grant    = r_grant;
    assign ch_done     = (r_state == ST_DONE) ? r_grant : '0;
    assign done_words  = r_done_words;
    assign busy        = (r_state != ST_IDLE);
    assign core_rst    = r_core_rst;
    assign core_ce     = w_run;

endmodule

// File: tb/tb_encode_sched.sv
// Scoreboard bench for encode_sched: stimulus queues expected completions, a monitor checks them.
module tb_encode_sched;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 4;

    logic              clk;
    logic              rstn;
    logic [NCH-1:0]    ch_req;
    logic [64*NCH-1:0] ch_fi;
    logic [NCH-1:0]    ch_src_empty;
    logic [NCH-1:0]    ch_last;
    logic [NCH-1:0]    ch_fo_full;
    logic [NCH-1:0]    ch_grant;
    logic [NCH-1:0]    ch_src_getn;
    logic [NCH-1:0]    ch_dst_putn;
    logic [63:0]       ch_dst;
    logic              ch_dst_last;
    logic [NCH-1:0]    ch_done;
    logic [CNT_W-1:0]  done_words;
    logic              busy;
    logic              core_rst;
    logic              core_ce;
    logic [63:0]       core_fi;
    logic              core_src_empty;
    logic              core_m_last;
    logic              core_fo_full;
    logic              core_src_getn;
    logic              core_dst_putn;
    logic [63:0]       core_dst;
    logic              core_dst_last;
    logic              core_endn;

    typedef struct packed {
        logic [NCH-1:0]   grant;
        logic [CNT_W-1:0] words;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    encode_sched #(.NCH(NCH), .CLR_CYCLES(4), .CNT_W(CNT_W)) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .ch_req         (ch_req),
        .ch_fi          (ch_fi),
        .ch_src_empty   (ch_src_empty),
        .ch_last        (ch_last),
        .ch_fo_full     (ch_fo_full),
        .ch_grant       (ch_grant),
        .ch_src_getn    (ch_src_getn),
        .ch_dst_putn    (ch_dst_putn),
        .ch_dst         (ch_dst),
        .ch_dst_last    (ch_dst_last),
        .ch_done        (ch_done),
        .done_words     (done_words),
        .busy           (busy),
        .core_rst       (core_rst),
        .core_ce        (core_ce),
        .core_fi        (core_fi),
        .core_src_empty (core_src_empty),
        .core_m_last    (core_m_last),
        .core_fo_full   (core_fo_full),
        .core_src_getn  (core_src_getn),
        .core_dst_putn  (core_dst_putn),
        .core_dst       (core_dst),
        .core_dst_last  (core_dst_last),
        .core_endn      (core_endn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest queued job.
    always @(negedge clk) begin
        if (rstn && (ch_done != '0)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_done actual=%0h required=none", ch_done);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_done_grant", 64'(ch_done), 64'(e.grant));
                chk("sb_done_words", 64'(done_words), 64'(e.words));
                chk("sb_grant_held", 64'(ch_grant), 64'(e.grant));
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 64'(ch_grant), 64'h0);
        chk({tag, "_done"}, 64'(ch_done), 64'h0);
        chk({tag, "_words"}, 64'(done_words), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_core_rst"}, 64'(core_rst), 64'h1);
        chk({tag, "_core_ce"}, 64'(core_ce), 64'h0);
        chk({tag, "_getn"}, 64'(ch_src_getn), 64'hF);
        chk({tag, "_putn"}, 64'(ch_dst_putn), 64'hF);
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic job(input logic [NCH-1:0] req, input int ch, input int npush,
                       input bit push_end, input bit glitch, input bit iso,
                       input logic [NCH-1:0] next_req);
        int   cnt;
        int   w;
        exp_t e;
        ch_req = req;
        for (int t = 0; t < 30 && !core_rst; t++) @(negedge clk);
        chk("grant_wait", 64'(core_rst), 64'h1);
        chk("grant_onehot", 64'(ch_grant), 64'(1 << ch));
        chk("busy_clear", 64'(busy), 64'h1);
        w = npush + int'(push_end);
        e.grant = NCH'(1 << ch);
        e.words = (w > 15) ? CNT_W'(15) : CNT_W'(w);
        sb_q.push_back(e);
        cnt = 0;
        while (core_rst && cnt < 20) begin
            if (cnt == 0) begin
                core_src_getn = 1'b0;
                core_dst_putn = 1'b0;
                #1;
                chk("clear_ce", 64'(core_ce), 64'h0);
                chk("clear_empty", 64'(core_src_empty), 64'h1);
                chk("clear_full", 64'(core_fo_full), 64'h1);
                chk("clear_fi", core_fi, 64'h0);
                chk("clear_getn", 64'(ch_src_getn), 64'hF);
                chk("clear_putn", 64'(ch_dst_putn), 64'hF);
                core_src_getn = 1'b1;
                core_dst_putn = 1'b1;
            end
            core_endn = !(glitch && cnt == 1);
            cnt++;
            @(negedge clk);
        end
        core_endn = 1'b1;
        chk("clear_len", 64'(cnt), 64'd4);
        chk("run_ce", 64'(core_ce), 64'h1);
        chk("run_core_rst", 64'(core_rst), 64'h0);
        for (int i = 0; i < npush; i++) begin
            core_dst_putn = 1'b0;
            if (iso && i == 0) begin
                ch_src_empty  = 4'b1101;
                ch_fo_full    = 4'b1101;
                ch_last       = 4'b0010;
                core_src_getn = 1'b0;
                core_dst      = 64'hFEED_0000_BEEF_0001;
                core_dst_last = 1'b1;
                #1;
                chk("iso_empty_a", 64'(core_src_empty), 64'h0);
                chk("iso_full_a", 64'(core_fo_full), 64'h0);
                chk("iso_last_a", 64'(core_m_last), 64'h1);
                chk("iso_fi", core_fi, 64'h1111_2222_3333_4444);
                chk("iso_getn_a", 64'(ch_src_getn), 64'hD);
                chk("iso_putn_a", 64'(ch_dst_putn), 64'hD);
                chk("iso_dst", ch_dst, 64'hFEED_0000_BEEF_0001);
                chk("iso_dst_last", 64'(ch_dst_last), 64'h1);
            end
            if (iso && i == 1) begin
                ch_src_empty  = 4'b0010;
                ch_fo_full    = 4'b0010;
                ch_last       = 4'b1101;
                core_src_getn = 1'b1;
                #1;
                chk("iso_empty_b", 64'(core_src_empty), 64'h1);
                chk("iso_full_b", 64'(core_fo_full), 64'h1);
                chk("iso_last_b", 64'(core_m_last), 64'h0);
                chk("iso_getn_b", 64'(ch_src_getn), 64'hF);
                chk("iso_putn_b", 64'(ch_dst_putn), 64'hD);
            end
            @(negedge clk);
        end
        core_dst_putn = push_end ? 1'b0 : 1'b1;
        core_endn     = 1'b0;
        @(negedge clk);
        core_dst_putn = 1'b1;
        core_endn     = 1'b1;
        core_src_getn = 1'b1;
        ch_src_empty  = '1;
        ch_fo_full    = '0;
        ch_last       = '0;
        ch_req        = next_req;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ch_req = '0;
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_release_core_rst", 64'(core_rst), 64'h0);
    endtask

    initial begin
        rstn          = 1'b0;
        ch_req        = '0;
        ch_fi         = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                         64'h1111_2222_3333_4444, 64'hAAAA_AAAA_AAAA_AAAA};
        ch_src_empty  = '1;
        ch_last       = '0;
        ch_fo_full    = '0;
        core_src_getn = 1'b1;
        core_dst_putn = 1'b1;
        core_dst      = '0;
        core_dst_last = 1'b0;
        core_endn     = 1'b1;
        @(negedge clk);
        do_reset();

        // Single job on channel 2, 10 pushes.
        job(4'b0100, 2, 10, 1'b0, 1'b0, 1'b0, 4'b0000);
        chk("single_done_busy", 64'(busy), 64'h1);
        @(negedge clk);
        chk("single_idle_busy", 64'(busy), 64'h0);
        chk("single_idle_grant", 64'(ch_grant), 64'h0);
        chk("single_done_pulse", 64'(ch_done), 64'h0);
        chk("single_words_held", 64'(done_words), 64'd10);

        // Fairness from a fresh pointer; channel 1 job also checks isolation.
        do_reset();
        job(4'b1111, 0, 3, 1'b0, 1'b0, 1'b0, 4'b1111);
        job(4'b1111, 1, 3, 1'b0, 1'b0, 1'b1, 4'b1111);
        job(4'b1111, 2, 3, 1'b0, 1'b0, 1'b0, 4'b1111);
        job(4'b1111, 3, 3, 1'b0, 1'b0, 1'b0, 4'b1111);
        job(4'b1111, 0, 3, 1'b0, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);

        // Saturation with endn glitch in CLEAR and a push alongside endn; then a small same-cycle push job.
        job(4'b0001, 0, 19, 1'b1, 1'b1, 1'b0, 4'b0000);
        @(negedge clk);
        job(4'b0010, 1, 5, 1'b1, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);

        // Reset mid-RUN.
        ch_req = 4'b1000;
        for (int t = 0; t < 30 && !core_ce; t++) @(negedge clk);
        chk("midrun_ce_wait", 64'(core_ce), 64'h1);
        core_dst_putn = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("midrun");
        core_dst_putn = 1'b1;
        ch_req = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrun_release_core_rst", 64'(core_rst), 64'h0);
        job(4'b0011, 0, 2, 1'b0, 1'b0, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
